// File: rtl/video_memory_pkg.sv
// video_memory_pkg
//   Shared definitions for the banked video SRAM front-end:
//   peripheral FSM state encoding, idle chip-select pattern,
//   byte-lane mask expansion and the address-split helper.
//   No ports (package).

package video_memory_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } periph_state_e;

  // Widest supported bank count; callers slice to BANK_COUNT.
  localparam int MAX_BANKS = 8;
  localparam logic [MAX_BANKS-1:0] CSB_IDLE = '1;

  typedef struct packed {
    logic [7:0]  bank;
    logic [23:0] word;
  } addr_split_t;

  // Byte address -> bank and word fields for a macro of 2**aw words
  // and 2**bb banks. Byte offset bits [1:0] are dropped.
  function automatic addr_split_t split_addr(input logic [23:0] addr,
                                             input int aw,
                                             input int bb);
    addr_split_t s;
    logic [23:0] word_mask;
    logic [23:0] bank_mask;
    logic [23:0] bank_full;
    word_mask = (24'd1 << aw) - 24'd1;
    bank_mask = (24'd1 << bb) - 24'd1;
    bank_full = (addr >> (aw + 2)) & bank_mask;
    s.word    = (addr >> 2) & word_mask;
    s.bank    = bank_full[7:0];
    return s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/video_memory_read_port.sv
// video_memory_read_port
//   Video fetch path onto the read-only SRAM ports. Drives csb1/addr1 in
//   the fetch cycle, registers the bank, and selects/merges the returned
//   word one cycle later. A peripheral write to the same bank/word in the
//   fetch cycle is forwarded into the returned word byte by byte.
//   Optional macro VIDEO_MEMORY_OUTPUT_REG_EN adds one output register
//   stage (data/valid at N+2 instead of N+1).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   fetch_i             video fetch strobe
//   bank_i, word_i      decoded video bank/word
//   wr_hit_i            peripheral write hits the same bank/word this cycle
//   wr_data_i/wr_mask_i peripheral write data and byte lanes
//   sram_csb1_o         r-port chip selects, active low
//   sram_addr1_o        r-port word address
//   sram_dout1_i        r-port read data, all banks
//   video_data_o        fetched word (holds between fetches)
//   video_dataValid_o   one-cycle valid strobe

module video_memory_read_port
  import video_memory_pkg::*;
#(
  parameter int SRAM_ADDRESS_SIZE = 9,
  parameter int BANK_COUNT        = 4,
  localparam int BANK_BITS        = $clog2(BANK_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_i,
  input  logic [BANK_BITS-1:0]         bank_i,
  input  logic [SRAM_ADDRESS_SIZE-1:0] word_i,
  input  logic                         wr_hit_i,
  input  logic [31:0]                  wr_data_i,
  input  logic [3:0]                   wr_mask_i,
  output logic [BANK_COUNT-1:0]        sram_csb1_o,
  output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr1_o,
  input  logic [32*BANK_COUNT-1:0]     sram_dout1_i,
  output logic [31:0]                  video_data_o,
  output logic                         video_dataValid_o
);

  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 valid_q;
  logic                 byp_q;
  logic [31:0]          byp_data_q;
  logic [3:0]           byp_mask_q;
  logic [31:0]          rd_word;
  logic [31:0]          byp_lanes;
  logic [31:0]          merged;

  always_comb begin
    sram_csb1_o = CSB_IDLE[BANK_COUNT-1:0];
    if (fetch_i) sram_csb1_o[bank_i] = 1'b0;
  end

  assign sram_addr1_o = word_i;
  assign bank_d       = fetch_i ? bank_i : bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= '0;
      valid_q    <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else begin
      bank_q  <= bank_d;
      valid_q <= fetch_i;
      byp_q   <= fetch_i & wr_hit_i;
      if (fetch_i && wr_hit_i) begin
        byp_data_q <= wr_data_i;
        byp_mask_q <= wr_mask_i;
      end
    end
  end

  // The SRAM returns the pre-write contents on a same-cycle collision,
  // so the written lanes are patched in from the captured write.
  assign rd_word   = sram_dout1_i[32*bank_q +: 32];
  assign byp_lanes = byp_q ? lane_mask(byp_mask_q) : '0;
  assign merged    = (byp_data_q & byp_lanes) | (rd_word & ~byp_lanes);

`ifdef VIDEO_MEMORY_OUTPUT_REG_EN
  logic        out_valid_q;
  logic [31:0] out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= valid_q;
      if (valid_q) out_data_q <= merged;
    end
  end

  assign video_data_o      = out_data_q;
  assign video_dataValid_o = out_valid_q;
`else
  logic [31:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (valid_q) begin
      hold_q <= merged;
    end
  end

  assign video_data_o      = valid_q ? merged : hold_q;
  assign video_dataValid_o = valid_q;
`endif

endmodule

// File: rtl/video_memory_banked.sv
// video_memory_banked
//   Banked video SRAM front-end. Joins a peripheral-bus read/write port
//   (rw port of each macro) and a video fetch port (r port of each macro)
//   onto BANK_COUNT dual-port 32-bit SRAMs. Peripheral reads run through a
//   two-state FSM (IDLE/RESPOND); writes complete in one IDLE cycle.
//   Optional macro VIDEO_MEMORY_OUTPUT_REG_EN (in video_memory_read_port)
//   adds an output register stage to the video path.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   peripheralBus_*                peripheral request/response
//   requestOutput                  accepted read in progress
//   video_fetchData/address/data/dataValid  video fetch port
//   sram_csb0/web0/wmask0/addr0/din0/dout0  SRAM rw ports
//   sram_csb1/addr1/dout1                   SRAM r ports

module video_memory_banked
  import video_memory_pkg::*;
#(
  parameter int SRAM_ADDRESS_SIZE   = 9,
  parameter int BANK_COUNT          = 4,
  parameter int PERIPHERAL_BUS_BASE = 0,
  localparam int BANK_BITS          = $clog2(BANK_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 peripheralBus_we,
  input  logic                                 peripheralBus_oe,
  output logic                                 peripheralBus_busy,
  input  logic [23:0]                          peripheralBus_address,
  input  logic [3:0]                           peripheralBus_byteSelect,
  input  logic [31:0]                          peripheralBus_dataWrite,
  output logic [31:0]                          peripheralBus_dataRead,
  output logic                                 requestOutput,
  input  logic                                 video_fetchData,
  input  logic [SRAM_ADDRESS_SIZE+BANK_BITS+1:0] video_address,
  output logic [31:0]                          video_data,
  output logic                                 video_dataValid,
  output logic [BANK_COUNT-1:0]                sram_csb0,
  output logic                                 sram_web0,
  output logic [3:0]                           sram_wmask0,
  output logic [SRAM_ADDRESS_SIZE-1:0]         sram_addr0,
  output logic [31:0]                          sram_din0,
  input  logic [32*BANK_COUNT-1:0]             sram_dout0,
  output logic [BANK_COUNT-1:0]                sram_csb1,
  output logic [SRAM_ADDRESS_SIZE-1:0]         sram_addr1,
  input  logic [32*BANK_COUNT-1:0]             sram_dout1
);

  localparam int UPPER_LSB = SRAM_ADDRESS_SIZE + 2 + BANK_BITS;
  localparam int UPPER_W   = 24 - UPPER_LSB;
  localparam logic [UPPER_W-1:0] BASE_V = UPPER_W'(PERIPHERAL_BUS_BASE);

  periph_state_e state_q, state_d;

  addr_split_t                  p_split, v_split;
  logic                         unused_split;
  logic [BANK_BITS-1:0]         p_bank, v_bank;
  logic [SRAM_ADDRESS_SIZE-1:0] p_word, v_word;
  logic                         addr_hit;
  logic                         wr_req, rd_req, rd_miss, wr_hit;

  logic [BANK_BITS-1:0] rd_bank_q, rd_bank_d;
  logic [3:0]           rd_be_q, rd_be_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          rd_masked;

  assign p_split = split_addr(peripheralBus_address, SRAM_ADDRESS_SIZE, BANK_BITS);
  assign v_split = split_addr(24'(video_address), SRAM_ADDRESS_SIZE, BANK_BITS);
  assign p_bank  = p_split.bank[BANK_BITS-1:0];
  assign p_word  = p_split.word[SRAM_ADDRESS_SIZE-1:0];
  assign v_bank  = v_split.bank[BANK_BITS-1:0];
  assign v_word  = v_split.word[SRAM_ADDRESS_SIZE-1:0];
  assign unused_split = ^{p_split, v_split};

  assign addr_hit = (peripheralBus_address[23:UPPER_LSB] == BASE_V);
  assign wr_req   = peripheralBus_we & addr_hit;
  assign rd_req   = peripheralBus_oe & ~peripheralBus_we & addr_hit;
  assign rd_miss  = peripheralBus_oe & ~peripheralBus_we & ~addr_hit;

  // Only an accepted write (IDLE) can collide with a video fetch.
  assign wr_hit = wr_req && (state_q == IDLE) && (p_bank == v_bank) && (p_word == v_word);

  assign sram_addr0 = p_word;
  assign sram_din0  = peripheralBus_dataWrite;
  assign rd_masked  = sram_dout0[32*rd_bank_q +: 32] & lane_mask(rd_be_q);

  always_comb begin
    state_d                = state_q;
    rd_bank_d              = rd_bank_q;
    rd_be_d                = rd_be_q;
    rdata_d                = rdata_q;
    peripheralBus_dataRead = rdata_q;
    peripheralBus_busy     = 1'b0;
    requestOutput          = 1'b0;
    sram_csb0              = CSB_IDLE[BANK_COUNT-1:0];
    sram_web0              = 1'b1;
    sram_wmask0            = '0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          sram_csb0[p_bank] = 1'b0;
          sram_web0         = 1'b0;
          sram_wmask0       = peripheralBus_byteSelect;
        end else if (rd_req) begin
          sram_csb0[p_bank]  = 1'b0;
          peripheralBus_busy = 1'b1;
          requestOutput      = 1'b1;
          rd_bank_d          = p_bank;
          rd_be_d            = peripheralBus_byteSelect;
          state_d            = RESPOND;
        end else if (rd_miss) begin
          rdata_d                = '0;
          peripheralBus_dataRead = '0;
        end
      end
      RESPOND: begin
        requestOutput          = 1'b1;
        rdata_d                = rd_masked;
        peripheralBus_dataRead = rd_masked;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_bank_q <= '0;
      rd_be_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_be_q   <= rd_be_d;
      rdata_q   <= rdata_d;
    end
  end

  video_memory_read_port #(
    .SRAM_ADDRESS_SIZE(SRAM_ADDRESS_SIZE),
    .BANK_COUNT       (BANK_COUNT)
  ) u_read_port (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_i          (video_fetchData),
    .bank_i           (v_bank),
    .word_i           (v_word),
    .wr_hit_i         (wr_hit),
    .wr_data_i        (peripheralBus_dataWrite),
    .wr_mask_i        (peripheralBus_byteSelect),
    .sram_csb1_o      (sram_csb1),
    .sram_addr1_o     (sram_addr1),
    .sram_dout1_i     (sram_dout1),
    .video_data_o     (video_data),
    .video_dataValid_o(video_dataValid)
  );

endmodule

// File: tb/tb_video_memory_banked.sv
module tb_video_memory_banked;

`ifdef VIDEO_MEMORY_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we, oe, busy, req_out, fetch, vvalid, web0;
  logic [23:0]  address;
  logic [3:0]   be, wmask0;
  logic [31:0]  wdata, rdata, vdata, din0;
  logic [12:0]  vaddr;
  logic [3:0]   csb0, csb1;
  logic [8:0]   addr0, addr1;
  logic [127:0] dout0, dout1;

  logic [31:0] mem [4][512];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int v_run  = 0;
  int v_max_run = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       tag;
  } vexp_t;
  vexp_t vq[$];

  video_memory_banked dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .peripheralBus_we        (we),
    .peripheralBus_oe        (oe),
    .peripheralBus_busy      (busy),
    .peripheralBus_address   (address),
    .peripheralBus_byteSelect(be),
    .peripheralBus_dataWrite (wdata),
    .peripheralBus_dataRead  (rdata),
    .requestOutput           (req_out),
    .video_fetchData         (fetch),
    .video_address           (vaddr),
    .video_data              (vdata),
    .video_dataValid         (vvalid),
    .sram_csb0               (csb0),
    .sram_web0               (web0),
    .sram_wmask0             (wmask0),
    .sram_addr0              (addr0),
    .sram_din0               (din0),
    .sram_dout0              (dout0),
    .sram_csb1               (csb1),
    .sram_addr1              (addr1),
    .sram_dout1              (dout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port SRAM model: synchronous read, byte-masked write.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!csb1[b]) dout1[b*32 +: 32] <= mem[b][addr1];
      if (!csb0[b]) begin
        if (web0) dout0[b*32 +: 32] <= mem[b][addr0];
        else
          for (int l = 0; l < 4; l++)
            if (wmask0[l]) mem[b][addr0][8*l +: 8] <= din0[8*l +: 8];
      end
    end
  end

  function automatic logic [31:0] pattern(input int b, input int w);
    return {8'hA5, 8'(b), 16'(w)};
  endfunction

  function automatic logic [23:0] paddr(input int b, input int w);
    return (24'(b) << 11) | (24'(w) << 2);
  endfunction

  function automatic logic [12:0] vad(input int b, input int w);
    logic [23:0] a;
    a = paddr(b, w);
    return a[12:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic push_video(input int b, input int w, input logic [31:0] exp, input string tag);
    vexp_t e;
    fetch = 1'b1;
    vaddr = vad(b, w);
    e.data = exp;
    e.cyc  = cyc;
    e.tag  = tag;
    vq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Video scoreboard: every valid strobe pops one expected word and
  // must arrive exactly LAT cycles after its fetch.
  always @(negedge clk) begin
    if (rst_n && vvalid) begin
      if (vq.size() == 0) begin
        check("video_unexpected_valid", 32'(vq.size()), 32'd1);
      end else begin
        vexp_t e;
        e = vq.pop_front();
        check(e.tag, vdata, e.data);
        check({e.tag, "_latency"}, 32'(cyc - e.cyc), 32'(LAT));
      end
      v_run++;
      if (v_run > v_max_run) v_max_run = v_run;
    end else begin
      v_run = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; oe = 1'b0; fetch = 1'b0;
    address = '0; be = '0; wdata = '0; vaddr = '0;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 512; w++)
        mem[b][w] <= pattern(b, w);
    mem[1][7] <= 32'h12345678;
    mem[2][9] <= 32'h11223344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_reqout",  32'(req_out), 32'd0);
    check("rst_dataRead", rdata,       32'd0);
    check("rst_vdata",   vdata,        32'd0);
    check("rst_vvalid",  32'(vvalid),  32'd0);
    check("rst_csb0",    32'(csb0),    32'hF);
    check("rst_csb1",    32'(csb1),    32'hF);
    check("rst_web0",    32'(web0),    32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full-word write to bank 2 word 5
    step();
    we = 1'b1; address = paddr(2, 5); be = 4'hF; wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_csb0",   32'(csb0),   32'hB);
    check("wr_web0",   32'(web0),   32'd0);
    check("wr_wmask0", 32'(wmask0), 32'hF);
    check("wr_addr0",  32'(addr0),  32'd5);
    check("wr_busy",   32'(busy),   32'd0);
    step();
    we = 1'b0;
    @(negedge clk);
    check("wr_done_csb0", 32'(csb0), 32'hF);
    check("wr_done_busy", 32'(busy), 32'd0);

    // Read back; oe held so a second read follows; write in RESPOND ignored
    step();
    oe = 1'b1; address = paddr(2, 5); be = 4'hF;
    @(negedge clk);
    check("rd_busy",   32'(busy),    32'd1);
    check("rd_reqout", 32'(req_out), 32'd1);
    check("rd_csb0",   32'(csb0),    32'hB);
    check("rd_web0",   32'(web0),    32'd1);
    step();
    we = 1'b1; wdata = 32'h0;
    @(negedge clk);
    check("rsp_busy",     32'(busy), 32'd0);
    check("rsp_dataRead", rdata,     32'hDEADBEEF);
    check("rsp_we_csb0",  32'(csb0), 32'hF);
    check("rsp_we_web0",  32'(web0), 32'd1);
    step();
    we = 1'b0;
    @(negedge clk);
    check("rd2_busy",     32'(busy), 32'd1);
    check("rd2_hold",     rdata,     32'hDEADBEEF);
    step();
    oe = 1'b0;
    @(negedge clk);
    check("rd2_dataRead", rdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    check("rd_hold_idle", rdata,     32'hDEADBEEF);
    check("rd_idle_csb0", 32'(csb0), 32'hF);

    // Partial-lane read
    step();
    oe = 1'b1; address = paddr(1, 7); be = 4'h3;
    step();
    oe = 1'b0;
    @(negedge clk);
    check("rd_partial", rdata, 32'h00005678);

    // Non-matching upper address field
    step();
    oe = 1'b1; address = paddr(1, 7) | 24'h002000; be = 4'hF;
    @(negedge clk);
    check("miss_rd_csb0",   32'(csb0),    32'hF);
    check("miss_rd_busy",   32'(busy),    32'd0);
    check("miss_rd_reqout", 32'(req_out), 32'd0);
    check("miss_dataRead",  rdata,        32'd0);
    step();
    we = 1'b1; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("miss_wr_csb0", 32'(csb0), 32'hF);
    check("miss_wr_web0", 32'(web0), 32'd1);
    step();
    we = 1'b0; oe = 1'b0;

    // Back-to-back video fetches across all banks
    v_max_run = 0;
    for (int b = 0; b < 4; b++) begin
      if (b != 0) step();
      push_video(b, 3, pattern(b, 3), $sformatf("video_b%0d", b));
      @(negedge clk);
      check($sformatf("video_csb1_b%0d", b), 32'(csb1), 32'(4'hF & ~(4'b1 << b)));
    end
    step();
    fetch = 1'b0;
    repeat (4) @(negedge clk);
    check("video_burst_run", 32'(v_max_run), 32'd4);
    check("video_q_empty",   32'(vq.size()), 32'd0);
    check("video_hold",      vdata,          pattern(3, 3));

    // Same-cycle write/fetch collision, then memory and bypass-clear checks
    step();
    we = 1'b1; address = paddr(2, 9); wdata = 32'hAABBCCDD; be = 4'h5;
    push_video(2, 9, 32'h11BB33DD, "collision_fwd");
    step();
    we = 1'b0;
    push_video(2, 9, 32'h11BB33DD, "collision_mem");
    step();
    push_video(2, 10, pattern(2, 10), "collision_next");
    step();
    fetch = 1'b0;
    repeat (4) @(negedge clk);
    check("collision_q_empty", 32'(vq.size()), 32'd0);

    // Reset asserted while in RESPOND
    step();
    oe = 1'b1; address = paddr(1, 7); be = 4'hF;
    step();
    oe = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_busy",     32'(busy),    32'd0);
    check("rstmid_reqout",   32'(req_out), 32'd0);
    check("rstmid_dataRead", rdata,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    oe = 1'b1; address = paddr(2, 5); be = 4'hF;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd1);
    step();
    oe = 1'b0;
    @(negedge clk);
    check("post_rst_dataRead", rdata, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    check("final_q_empty", 32'(vq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
